// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: iterative 32x32 multiply / divide controller.
// Four-state FSM (IDLE, RUN, FIX, DONE). RUN performs 32 shift-add or
// restoring shift-subtract steps on operand magnitudes. FIX loads HI/LO.
// Define MULT_DIV_SIGNED_EN for two's-complement operands with sign
// correction in FIX. Leave it undefined for unsigned operation.
module mult_div_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t          state, state_n;
    logic            busy_n, done_n, div_zero_n;
    logic            op_div;
    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  acc;
    logic [W-1:0]    divisor;
    logic            accept_mult_c, accept_div_c, zero_div_c;
    logic [W:0]      mul_sum_c;
    logic [W:0]      div_sh_c;
    logic [W:0]      div_diff_c;
    logic [2*W-1:0]  step_c;
    logic [W-1:0]    hi_fix_c, lo_fix_c;
`ifdef MULT_DIV_SIGNED_EN
    logic            neg_q, neg_r;
    logic [2*W-1:0]  prod_fix_c;
    logic [W-1:0]    quo_fix_c, rem_fix_c;
`endif

    // Operand magnitude; identity for unsigned operands.
    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
`ifdef MULT_DIV_SIGNED_EN
        return x[W-1] ? W'(-x) : x;
`else
        return x;
`endif
    endfunction

    // Start decode; multiply has priority over divide.
    always_comb begin
        accept_mult_c = (state == IDLE) && start_mult;
        accept_div_c  = (state == IDLE) && start_div && !start_mult && (b != '0);
        zero_div_c    = (state == IDLE) && start_div && !start_mult && (b == '0);
    end

    // One iteration: shift-add multiply or restoring divide on acc.
    always_comb begin
        mul_sum_c  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, divisor} : (W+1)'(0));
        div_sh_c   = {acc[2*W-1:W], acc[W-1]};
        div_diff_c = div_sh_c - {1'b0, divisor};
        if (op_div) begin
            if (div_sh_c >= {1'b0, divisor})
                step_c = {div_diff_c[W-1:0], acc[W-2:0], 1'b1};
            else
                step_c = {div_sh_c[W-1:0], acc[W-2:0], 1'b0};
        end else begin
            step_c = {mul_sum_c, acc[W-1:1]};
        end
    end

    // Result selection with optional sign correction.
    always_comb begin
`ifdef MULT_DIV_SIGNED_EN
        prod_fix_c = neg_q ? (2*W)'(-acc) : acc;
        quo_fix_c  = neg_q ? W'(-acc[W-1:0]) : acc[W-1:0];
        rem_fix_c  = neg_r ? W'(-acc[2*W-1:W]) : acc[2*W-1:W];
        hi_fix_c   = op_div ? rem_fix_c : prod_fix_c[2*W-1:W];
        lo_fix_c   = op_div ? quo_fix_c : prod_fix_c[W-1:0];
`else
        hi_fix_c   = acc[2*W-1:W];
        lo_fix_c   = acc[W-1:0];
`endif
    end

    // State and status-output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state    <= state_n;
            busy     <= busy_n;
            done     <= done_n;
            div_zero <= div_zero_n;
        end
    end

    // Next state; status outputs decoded from the state being entered.
    always_comb begin
        state_n    = state;
        busy_n     = 1'b0;
        done_n     = 1'b0;
        div_zero_n = 1'b0;
        case (state)
            IDLE: begin
                if (accept_mult_c || accept_div_c) begin
                    state_n = RUN;
                    busy_n  = 1'b1;
                end else if (zero_div_c) begin
                    state_n    = DONE;
                    done_n     = 1'b1;
                    div_zero_n = 1'b1;
                end
            end
            RUN: begin
                busy_n = 1'b1;
                if (cnt == CW'(31)) state_n = FIX;
            end
            FIX: begin
                state_n = DONE;
                done_n  = 1'b1;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and HI/LO load in FIX.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_div  <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            divisor <= '0;
            hi_out  <= '0;
            lo_out  <= '0;
`ifdef MULT_DIV_SIGNED_EN
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept_mult_c || accept_div_c) begin
                        op_div  <= !start_mult;
                        cnt     <= '0;
                        acc     <= {{W{1'b0}}, mag(a)};
                        divisor <= mag(b);
`ifdef MULT_DIV_SIGNED_EN
                        neg_q   <= a[W-1] ^ b[W-1];
                        neg_r   <= a[W-1];
`endif
                    end
                end
                RUN: begin
                    acc <= step_c;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    hi_out <= hi_fix_c;
                    lo_out <= lo_fix_c;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard testbench for mult_div_ctrl (builds with or without MULT_DIV_SIGNED_EN).
module tb_mult_div_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_mult, start_div;
    logic [31:0] a, b;
    logic        busy, done, div_zero;
    logic [31:0] hi_out, lo_out;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_hi = 0, last_lo = 0;

    mult_div_ctrl dut (
        .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
        .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic on the operands.
    function automatic exp_t model(input logic mult, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
`ifdef MULT_DIV_SIGNED_EN
        longint sx, sy, p, q, r;
`else
        logic [63:0] p;
`endif
        e.dz = 1'b0;
        if (!mult && y == 32'd0) begin
            e.hi = last_hi;
            e.lo = last_lo;
            e.dz = 1'b1;
            return e;
        end
`ifdef MULT_DIV_SIGNED_EN
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (mult) begin
            p = sx * sy;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else begin
            q = sx / sy;
            r = sx % sy;
            e.hi = r[31:0];
            e.lo = q[31:0];
        end
`else
        if (mult) begin
            p = 64'(x) * 64'(y);
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else begin
            e.hi = x % y;
            e.lo = x / y;
        end
`endif
        return e;
    endfunction

    // Monitor: pop and compare on every done pulse; div_zero must be low otherwise.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (done === 1'b1) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 required no pending op at %0t", $time);
                end else begin
                    e = expq.pop_front();
                    chk("hi_out", 64'(hi_out), 64'(e.hi));
                    chk("lo_out", 64'(lo_out), 64'(e.lo));
                    chk("div_zero", 64'(div_zero), 64'(e.dz));
                end
            end else if (reset === 1'b0) begin
                chk("div_zero_idle", 64'(div_zero), 64'd0);
            end
        end
    end

    // Issue one operation from a negedge; checks latency and busy length.
    task automatic run_op(input logic m, input logic d, input logic [31:0] x,
                          input logic [31:0] y, input int glitch_at);
        exp_t e;
        int   n, bc;
        start_mult = m;
        start_div  = d;
        a = x;
        b = y;
        e = model(m, x, y);
        expq.push_back(e);
        last_hi = e.hi;
        last_lo = e.lo;
        @(posedge clock);
        #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        a = $urandom;
        b = $urandom;
        n  = 0;
        bc = 0;
        while (n < 60) begin
            @(negedge clock);
            if (busy) bc++;
            start_div = (n == glitch_at);
            if (done) break;
            n++;
        end
        start_div = 1'b0;
        chk("latency", 64'(n), e.dz ? 64'd0 : 64'd33);
        chk("busy_cycles", 64'(bc), e.dz ? 64'd0 : 64'd33);
        @(negedge clock);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic        seen;
        logic [31:0] y;
        int          op;
        reset = 1'b1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi_out), 64'd0);
        chk("rst_lo", 64'(lo_out), 64'd0);
        reset = 1'b0;

        // Directed corners; the first is accepted on the first edge after reset.
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, -1);
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, -1);
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op(1'b0, 1'b1, 32'h0000_06D7, 32'h33, -1);
        chk("preload_hi", 64'(hi_out), 64'h11);
        chk("preload_lo", 64'(lo_out), 64'h22);
        run_op(1'b0, 1'b1, 32'd5, 32'd0, -1);
        run_op(1'b1, 1'b1, 32'd3, 32'd4, 5);
        run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2, -1);
        run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h10, -1);
        run_op(1'b0, 1'b1, 32'd0, 32'd0, -1);

        // Randomized mix of multiply, divide, simultaneous start and divide-by-zero.
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 3);
            y  = pick();
            if (op == 3) y = 32'd0;
            else if (op == 1 && y == 32'd0) y = 32'd1;
            run_op(op != 1 && op != 3, op != 0, pick(), y, (i % 4 == 0) ? 7 : -1);
        end

        // Abort a multiply at RUN cycle 10.
        start_mult = 1'b1;
        a = $urandom;
        b = $urandom;
        @(posedge clock);
        #1;
        start_mult = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hi", 64'(hi_out), 64'd0);
        chk("abort_lo", 64'(lo_out), 64'd0);
        last_hi = '0;
        last_lo = '0;
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done) seen = 1'b1;
        end
        chk("no_done_after_abort", 64'(seen), 64'd0);

        // Operation after abort starts from cleared state.
        run_op(1'b0, 1'b1, 32'd100, 32'd7, -1);
        chk("queue_empty", 64'(expq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
